// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with a single registered output slot.
// Channel choice is either a fixed select (MODE 0) or round-robin from ptr (MODE 1).
module mux_arb_n #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MODE     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS*WIDTH-1:0]     in_data,
   input  logic [CHANNELS-1:0]           in_valid,
   output logic [CHANNELS-1:0]           in_ready,
   input  logic [$clog2(CHANNELS)-1:0]   sel,
   output logic [WIDTH-1:0]              out_data,
   output logic [$clog2(CHANNELS)-1:0]   out_chan,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int SEL_W = $clog2(CHANNELS);

   logic [WIDTH-1:0] ch_data [CHANNELS];
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] idx;
   logic             found;
   logic             load_en;
   logic             take;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         ch_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   // The output slot can take a new word when empty or draining this cycle.
   assign load_en = !out_valid || out_ready;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      if (MODE == 0) begin
         grant = sel;
         found = 1'b1;
      end else begin
         for (int j = 0; j < CHANNELS; j++) begin
            idx = ptr + SEL_W'(j);
            if (!found && in_valid[idx]) begin
               grant = idx;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (load_en && found) begin
         in_ready[grant] = 1'b1;
      end
   end

   assign take = load_en && found && in_valid[grant];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         if (take) begin
            out_data  <= ch_data[grant];
            out_chan  <= grant;
            out_valid <= 1'b1;
            ptr       <= grant + SEL_W'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed and randomized checks of mux_arb_n in fixed-select and round-robin modes.
`timescale 1ns/1ps
module tb_mux_arb_n;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [63:0] m0_in_data, m1_in_data;
   logic [3:0]  m0_in_valid, m1_in_valid;
   logic [3:0]  m0_in_ready, m1_in_ready;
   logic [1:0]  m0_sel, m1_sel;
   logic [15:0] m0_out_data, m1_out_data;
   logic [1:0]  m0_out_chan, m1_out_chan;
   logic        m0_out_valid, m1_out_valid;
   logic        m0_out_ready, m1_out_ready;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mux_arb_n #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .in_data(m0_in_data), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
      .sel(m0_sel),
      .out_data(m0_out_data), .out_chan(m0_out_chan),
      .out_valid(m0_out_valid), .out_ready(m0_out_ready)
   );

   mux_arb_n #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .in_data(m1_in_data), .in_valid(m1_in_valid), .in_ready(m1_in_ready),
      .sel(m1_sel),
      .out_data(m1_out_data), .out_chan(m1_out_chan),
      .out_valid(m1_out_valid), .out_ready(m1_out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_rdy(input int mode, input logic [3:0] v,
                                          input logic [1:0] s, input logic [1:0] p,
                                          input logic le);
      logic [3:0] r;
      logic [1:0] k;
      r = '0;
      if (le) begin
         if (mode == 0) r[s] = 1'b1;
         else begin
            for (int j = 0; j < 4; j++) begin
               k = p + 2'(j);
               if (v[k] && r == 4'b0) r[k] = 1'b1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) if (oh[j]) r = 2'(j);
      return r;
   endfunction

   logic [17:0] q0[$], q1[$];
   logic [17:0] w;
   logic        ov0, ov1, le;
   logic [1:0]  p1, k;
   logic [3:0]  er;

   initial begin
      rst_n        = 1'b0;
      m0_in_data   = '0; m1_in_data = '0;
      m0_in_valid  = '0; m1_in_valid = '0;
      m0_sel       = '0; m1_sel = '0;
      m0_out_ready = 1'b1; m1_out_ready = 1'b1;
      #12;
      check("rst_ov0", m0_out_valid, 0);
      check("rst_data0", m0_out_data, 0);
      check("rst_chan0", m0_out_chan, 0);
      check("rst_ov1", m1_out_valid, 0);
      rst_n = 1'b1;
      tick();

      // Fixed-select mode
      m0_in_data  = {16'h7777, 16'h5a5a, 16'h00e3, 16'h0239};
      m0_in_valid = 4'b1111;
      m0_sel      = 2'd0;
      #1 check("fix_rdy_s0", m0_in_ready, 4'b0001);
      tick();
      check("fix_data_s0", m0_out_data, 16'h0239);
      check("fix_chan_s0", m0_out_chan, 0);
      check("fix_ov_s0", m0_out_valid, 1);
      m0_sel = 2'd1;
      #1 check("fix_rdy_s1", m0_in_ready, 4'b0010);
      tick();
      check("fix_data_s1", m0_out_data, 16'h00e3);
      check("fix_chan_s1", m0_out_chan, 1);
      m0_out_ready = 1'b0; m0_sel = 2'd2;
      #1 check("fix_stall_rdy", m0_in_ready, 4'b0000);
      tick();
      check("fix_stall_data", m0_out_data, 16'h00e3);
      check("fix_stall_chan", m0_out_chan, 1);
      check("fix_stall_ov", m0_out_valid, 1);
      m0_sel = 2'd3;
      #1 check("fix_stall_rdy2", m0_in_ready, 4'b0000);
      tick();
      check("fix_stall_chan2", m0_out_chan, 1);
      m0_out_ready = 1'b1; m0_sel = 2'd2;
      #1 check("fix_resume_rdy", m0_in_ready, 4'b0100);
      tick();
      check("fix_resume_data", m0_out_data, 16'h5a5a);
      check("fix_resume_chan", m0_out_chan, 2);
      m0_in_valid = 4'b0000;
      #1 check("fix_rdy_novalid", m0_in_ready, 4'b0100);
      tick();
      check("fix_drain_ov", m0_out_valid, 0);
      check("fix_drain_data", m0_out_data, 16'h5a5a);
      check("fix_drain_chan", m0_out_chan, 2);

      // Round-robin mode
      m1_in_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      m1_in_valid = 4'b1111;
      #1 check("rr_rdy_first", m1_in_ready, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rr_seq_chan", m1_out_chan, 32'(i % 4));
         check("rr_seq_data", m1_out_data, 32'h1000 + 32'(i % 4));
         check("rr_seq_ov", m1_out_valid, 1);
      end
      m1_in_valid = 4'b0101;
      #1 check("rr_skip_rdy", m1_in_ready, 4'b0100);
      tick();
      check("rr_skip_chan", m1_out_chan, 2);
      check("rr_wrap_rdy", m1_in_ready, 4'b0001);
      tick();
      check("rr_wrap_chan", m1_out_chan, 0);
      check("rr_wrap_data", m1_out_data, 16'h1000);
      m1_in_valid = 4'b0000;
      tick();
      check("rr_idle_ov", m1_out_valid, 0);

      m1_in_data[63:48] = 16'hBEEF;
      m1_in_valid = 4'b1000;
      #1 check("bp_load_rdy", m1_in_ready, 4'b1000);
      tick();
      check("bp_load_data", m1_out_data, 16'hBEEF);
      check("bp_load_chan", m1_out_chan, 3);
      m1_in_valid = 4'b1111; m1_out_ready = 1'b0;
      #1 check("bp_rdy0", m1_in_ready, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_data", m1_out_data, 16'hBEEF);
         check("bp_hold_ov", m1_out_valid, 1);
         check("bp_hold_rdy", m1_in_ready, 4'b0000);
      end
      m1_out_ready = 1'b1;
      #1 check("bp_release_rdy", m1_in_ready, 4'b0001);
      tick();
      check("bp_next_chan", m1_out_chan, 0);
      check("bp_next_data", m1_out_data, 16'h1000);

      // Asynchronous reset between edges while a word is held
      #2 rst_n = 1'b0;
      #1;
      check("arst_ov", m1_out_valid, 0);
      check("arst_data", m1_out_data, 0);
      check("arst_chan", m1_out_chan, 0);
      check("arst_ptr_rdy", m1_in_ready, 4'b0001);
      rst_n = 1'b1;
      tick();
      check("arst_first_chan", m1_out_chan, 0);
      check("arst_first_ov", m1_out_valid, 1);

      // Randomized traffic against a reference model and scoreboard
      m0_in_valid = '0; m1_in_valid = '0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      ov0 = 1'b0; ov1 = 1'b0; p1 = '0;
      for (int c = 0; c < 3000; c++) begin
         m0_in_valid  = 4'($urandom_range(0, 15));
         m1_in_valid  = 4'($urandom_range(0, 15));
         m0_out_ready = ($urandom_range(0, 3) != 0);
         m1_out_ready = ($urandom_range(0, 3) != 0);
         m0_sel       = 2'($urandom_range(0, 3));
         m1_sel       = 2'($urandom_range(0, 3));
         m0_in_data   = {$urandom, $urandom};
         m1_in_data   = {$urandom, $urandom};
         #1;

         le = !ov0 || m0_out_ready;
         er = exp_rdy(0, m0_in_valid, m0_sel, 2'd0, le);
         check("rnd_fix_rdy", m0_in_ready, er);
         check("rnd_fix_ov", m0_out_valid, ov0);
         if (ov0 && m0_out_ready) begin
            check("rnd_fix_qsize", q0.size(), 1);
            if (q0.size() > 0) begin
               w = q0.pop_front();
               check("rnd_fix_word", {m0_out_chan, m0_out_data}, w);
            end
         end
         if ((m0_in_valid & er) != 4'b0) begin
            k = oh_idx(er);
            q0.push_back({k, m0_in_data[k*16 +: 16]});
            ov0 = 1'b1;
         end else if (m0_out_ready) ov0 = 1'b0;

         le = !ov1 || m1_out_ready;
         er = exp_rdy(1, m1_in_valid, 2'd0, p1, le);
         check("rnd_rr_rdy", m1_in_ready, er);
         check("rnd_rr_ov", m1_out_valid, ov1);
         if (ov1 && m1_out_ready) begin
            check("rnd_rr_qsize", q1.size(), 1);
            if (q1.size() > 0) begin
               w = q1.pop_front();
               check("rnd_rr_word", {m1_out_chan, m1_out_data}, w);
            end
         end
         if ((m1_in_valid & er) != 4'b0) begin
            k = oh_idx(er);
            q1.push_back({k, m1_in_data[k*16 +: 16]});
            ov1 = 1'b1;
            p1  = k + 2'd1;
         end else if (m1_out_ready) ov1 = 1'b0;

         tick();
      end
      check("rnd_fix_final_ov", m0_out_valid, ov0);
      check("rnd_rr_final_ov", m1_out_valid, ov1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
